// File: rtl/nav_pkg.sv
// Shared types and helper functions for the grid navigation controller.
package nav_pkg;

  // Heading codes as seen on the dir output.
  typedef enum logic [2:0] {
    DIR_N = 3'b001,
    DIR_O = 3'b010,
    DIR_L = 3'b011,
    DIR_S = 3'b100
  } dir_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECIDE = 3'd1,
    ST_GIRA   = 3'd2,
    ST_ANDA   = 3'd3,
    ST_ESPERA = 3'd4
  } state_t;

  // Coordinates are zero-extended to this width before comparison.
  localparam int CW = 16;

  // One 90-degree left turn: N->O->S->L->N. Unknown codes recover to N.
  function automatic dir_t next_dir(input dir_t d);
    case (d)
      DIR_N:   next_dir = DIR_O;
      DIR_O:   next_dir = DIR_S;
      DIR_S:   next_dir = DIR_L;
      default: next_dir = DIR_N;
    endcase
  endfunction

  // Heading that closes the distance to the target; x is resolved before y.
  function automatic dir_t want_dir(input logic [CW-1:0] x, input logic [CW-1:0] y,
                                    input logic [CW-1:0] tx, input logic [CW-1:0] ty);
    if (tx > x)      want_dir = DIR_L;
    else if (tx < x) want_dir = DIR_O;
    else if (ty > y) want_dir = DIR_N;
    else if (ty < y) want_dir = DIR_S;
    else             want_dir = DIR_N;
  endfunction

endpackage

// File: rtl/nav_wait_timer.sv
// Settle timer: loaded when a girar/avancar pulse ends, counts down while
// the controller waits, and flags the last waiting cycle.
module nav_wait_timer #(
  parameter int WAIT_CYC = 2
) (
  input  logic c1,
  input  logic reset,
  input  logic load,
  input  logic run,
  output logic expired
);

  localparam int CNT_W = $clog2(WAIT_CYC + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT_CYC);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [CNT_W-1:0] cnt;

  // Countdown register; reaches 1 on the final waiting cycle.
  always_ff @(posedge c1) begin
    if (!reset)                  cnt <= '0;
    else if (load)               cnt <= LOAD_VAL;
    else if (run && cnt != '0)   cnt <= cnt - ONE;
  end

  assign expired = (cnt <= ONE);

endmodule

// File: rtl/navegacao_ctrl.sv
// Navigation sequencer: turns and advances the robot one grid cell at a
// time toward a commanded target, with a settle wait after every pulse.
//
// Handshake: cmd_ready is high only in IDLE and depends on state alone; a
// command transfers on a posedge c1 where cmd_valid & cmd_ready are both 1.
// cmd_valid while busy is ignored, and the source may change cmd_x/cmd_y
// freely until the transfer edge.
module navegacao_ctrl
  import nav_pkg::*;
#(
  parameter int W        = 4,
  parameter int WAIT_CYC = 2
) (
  input  logic         c1,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [W-1:0] cmd_x,
  input  logic [W-1:0] cmd_y,
  input  logic         obstaculo,
  output logic         girar,
  output logic         avancar,
  output logic [2:0]   dir,
  output logic [W-1:0] pos_x,
  output logic [W-1:0] pos_y,
  output logic         busy,
  output logic         done,
  output logic         erro,
  output logic [2:0]   dbg_state
);

  state_t       state, state_nxt;
  dir_t         dir_q, dir_want;
  logic [W-1:0] px, py, tx, ty;
  logic         done_q, erro_q;
  logic         at_target, timer_expired;

  assign at_target = (px == tx) && (py == ty);
  assign dir_want  = want_dir(CW'(px), CW'(py), CW'(tx), CW'(ty));

  nav_wait_timer #(.WAIT_CYC(WAIT_CYC)) u_timer (
    .c1      (c1),
    .reset   (reset),
    .load    ((state == ST_GIRA) || (state == ST_ANDA)),
    .run     (state == ST_ESPERA),
    .expired (timer_expired)
  );

  // State register.
  always_ff @(posedge c1) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decision; target check has priority over turning, turning over obstacle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (cmd_valid) state_nxt = ST_DECIDE;
      ST_DECIDE: begin
        if (at_target)               state_nxt = ST_IDLE;
        else if (dir_q != dir_want)  state_nxt = ST_GIRA;
        else if (obstaculo)          state_nxt = ST_IDLE;
        else                         state_nxt = ST_ANDA;
      end
      ST_GIRA:   state_nxt = ST_ESPERA;
      ST_ANDA:   state_nxt = ST_ESPERA;
      ST_ESPERA: if (timer_expired) state_nxt = ST_DECIDE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Position, heading, latched target and status flags.
  always_ff @(posedge c1) begin
    if (!reset) begin
      px     <= '0;
      py     <= '0;
      tx     <= '0;
      ty     <= '0;
      dir_q  <= DIR_N;
      done_q <= 1'b0;
      erro_q <= 1'b0;
    end else begin
      done_q <= (state == ST_DECIDE) && at_target;
      if (state == ST_IDLE && cmd_valid) begin
        tx     <= cmd_x;
        ty     <= cmd_y;
        erro_q <= 1'b0;
      end
      if (state == ST_DECIDE && !at_target && dir_q == dir_want && obstaculo)
        erro_q <= 1'b1;
      if (state == ST_GIRA)
        dir_q <= next_dir(dir_q);
      if (state == ST_ANDA) begin
        case (dir_q)
          DIR_N:   py <= py + 1'b1;
          DIR_S:   py <= py - 1'b1;
          DIR_L:   px <= px + 1'b1;
          DIR_O:   px <= px - 1'b1;
          default: px <= px;
        endcase
      end
    end
  end

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = ~cmd_ready;
  assign girar     = (state == ST_GIRA);
  assign avancar   = (state == ST_ANDA);
  assign done      = done_q;
  assign erro      = erro_q;
  assign dir       = dir_q;
  assign pos_x     = px;
  assign pos_y     = py;
  assign dbg_state = state;

endmodule

// File: tb/tb_navegacao_ctrl.sv
// Bench for navegacao_ctrl: directed scenarios plus random targets, checked
// against a path model that walks the grid with plain integer arithmetic.
module tb_navegacao_ctrl;

  localparam int W        = 4;
  localparam int WAIT_CYC = 2;
  localparam int CMD_BUDGET = 300;

  // ---------------- clock / reset ----------------
  logic         c1 = 1'b0;
  logic         reset = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         obstaculo = 1'b0;
  logic [W-1:0] cmd_x = '0;
  logic [W-1:0] cmd_y = '0;
  logic         cmd_ready, girar, avancar, busy, done, erro;
  logic [2:0]   dir, dbg_state;
  logic [W-1:0] pos_x, pos_y;

  always #5 c1 = ~c1;

  navegacao_ctrl #(.W(W), .WAIT_CYC(WAIT_CYC)) dut (
    .c1        (c1),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_x     (cmd_x),
    .cmd_y     (cmd_y),
    .obstaculo (obstaculo),
    .girar     (girar),
    .avancar   (avancar),
    .dir       (dir),
    .pos_x     (pos_x),
    .pos_y     (pos_y),
    .busy      (busy),
    .done      (done),
    .erro      (erro),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int passes = 0;
  logic [2*W-1:0] exp_q[$];      // expected {x,y} after each advance
  logic [2:0]     exp_dir_q[$];  // expected heading after each turn

  // Reference robot: heading as quarter-turns to the left of north.
  int mx, my, mh;
  int exp_turns, exp_adv, exp_lat;
  bit exp_err, exp_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) passes++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
  endtask

  function automatic logic [2:0] code_of(input int h);
    case (h)
      0:       code_of = 3'b001;  // N
      1:       code_of = 3'b010;  // O (west)
      2:       code_of = 3'b100;  // S
      default: code_of = 3'b011;  // L (east)
    endcase
  endfunction

  // Walk the grid toward (tx,ty); the advance attempt numbered block_k is blocked.
  task automatic plan(input int tx, input int ty, input int block_k);
    int attempts;
    int want;
    exp_q.delete();
    exp_dir_q.delete();
    exp_turns = 0;
    exp_adv   = 0;
    exp_err   = 0;
    attempts  = 0;
    while (!(mx == tx && my == ty)) begin
      if (tx > mx)      want = 3;
      else if (tx < mx) want = 1;
      else if (ty > my) want = 0;
      else              want = 2;
      while (mh != want) begin
        mh = (mh + 1) % 4;
        exp_turns++;
        exp_dir_q.push_back(code_of(mh));
      end
      if (attempts == block_k) begin
        exp_err = 1;
        break;
      end
      attempts++;
      case (want)
        0:       my = my + 1;
        2:       my = my - 1;
        3:       mx = mx + 1;
        default: mx = mx - 1;
      endcase
      exp_adv++;
      exp_q.push_back({mx[W-1:0], my[W-1:0]});
    end
    exp_done = !exp_err;
    // Each action costs DECIDE + pulse + settle; one final DECIDE returns to IDLE.
    exp_lat = (2 + WAIT_CYC) * (exp_turns + exp_adv) + 1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge c1);
    reset = 1'b0;
    repeat (2) @(posedge c1);
    @(negedge c1);
    reset = 1'b1;
    mx = 0; my = 0; mh = 0;
  endtask

  task automatic run_cmd(input string tag, input int tx, input int ty, input int block_k);
    int e, adv, turns, act_idx, lat, done_cnt;
    bit pend_adv, pend_turn, finished, excl_bad, done_at_end;
    logic [2*W-1:0] ep;
    plan(tx, ty, block_k);
    adv = 0; turns = 0; act_idx = 0; lat = -1; done_cnt = 0;
    pend_adv = 0; pend_turn = 0; finished = 0; excl_bad = 0; done_at_end = 0;
    @(negedge c1);
    check({tag, " ready before accept"}, cmd_ready, 1);
    cmd_x = tx[W-1:0];
    cmd_y = ty[W-1:0];
    cmd_valid = 1'b1;
    obstaculo = (block_k == 0);
    @(posedge c1);  // accept edge 0
    e = 0;
    while (!finished && e < CMD_BUDGET) begin
      @(negedge c1);
      cmd_valid = 1'b0;
      if (e == 0) check({tag, " erro cleared on accept"}, erro, 0);
      if (pend_adv && exp_q.size() > 0) begin
        ep = exp_q.pop_front();
        check({tag, " pos after advance"}, {pos_x, pos_y}, ep);
      end
      if (pend_turn && exp_dir_q.size() > 0)
        check({tag, " dir after turn"}, dir, exp_dir_q.pop_front());
      pend_adv = 0;
      pend_turn = 0;
      if (int'(girar) + int'(avancar) + int'(done) > 1) excl_bad = 1;
      if (girar || avancar) begin
        check({tag, " action edge"}, e, 1 + (2 + WAIT_CYC) * act_idx);
        act_idx++;
      end
      if (avancar) begin
        adv++;
        pend_adv = 1;
        if (adv == block_k) obstaculo = 1'b1;
      end
      if (girar) begin
        turns++;
        pend_turn = 1;
      end
      if (done) done_cnt++;
      if (cmd_ready) begin
        finished = 1;
        lat = e;
        done_at_end = done;
      end
      e++;
    end
    check({tag, " finished in budget"}, finished, 1);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " turns"}, turns, exp_turns);
    check({tag, " advances"}, adv, exp_adv);
    check({tag, " done on first idle"}, done_at_end, exp_done);
    check({tag, " done count"}, done_cnt, exp_done);
    check({tag, " erro"}, erro, exp_err);
    check({tag, " pos_x"}, pos_x, mx);
    check({tag, " pos_y"}, pos_y, my);
    check({tag, " dir"}, dir, code_of(mh));
    check({tag, " pulses exclusive"}, excl_bad, 0);
    @(negedge c1);
    check({tag, " done single cycle"}, done, 0);
    obstaculo = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int e;
    bit girar_seen, ready_while_busy, done_seen;
    int rx, ry, rk;

    // Reset state
    reset = 1'b0;
    repeat (2) @(posedge c1);
    @(negedge c1);
    check("reset pos_x", pos_x, 0);
    check("reset pos_y", pos_y, 0);
    check("reset dir", dir, 3'b001);
    check("reset cmd_ready", cmd_ready, 1);
    check("reset busy", busy, 0);
    check("reset girar", girar, 0);
    check("reset avancar", avancar, 0);
    check("reset done", done, 0);
    check("reset erro", erro, 0);
    reset = 1'b1;
    mx = 0; my = 0; mh = 0;

    run_cmd("straight", 0, 2, -1);

    do_reset();
    run_cmd("three turns", 1, 0, -1);

    do_reset();
    run_cmd("obstacle", 0, 3, 1);
    run_cmd("after obstacle", 0, 1, -1);

    // Busy: second command held valid is ignored; reset after the first turn.
    @(negedge c1);
    cmd_x = 4'd2; cmd_y = 4'd2; cmd_valid = 1'b1;
    @(posedge c1);
    @(negedge c1);
    cmd_x = 4'd5; cmd_y = 4'd5;
    girar_seen = 0; ready_while_busy = 0; done_seen = 0;
    e = 0;
    while (!girar_seen && e < 20) begin
      if (cmd_ready) ready_while_busy = 1;
      if (done) done_seen = 1;
      if (girar) girar_seen = 1;
      else @(negedge c1);
      e++;
    end
    check("busy girar seen", girar_seen, 1);
    check("busy ready stays low", ready_while_busy, 0);
    reset = 1'b0;   // cmd_valid stays high: reset must win over accept
    @(negedge c1);
    if (done) done_seen = 1;
    @(negedge c1);
    if (done) done_seen = 1;
    check("midreset pos_x", pos_x, 0);
    check("midreset pos_y", pos_y, 0);
    check("midreset dir", dir, 3'b001);
    check("midreset ready", cmd_ready, 1);
    check("midreset erro", erro, 0);
    cmd_valid = 1'b0;
    reset = 1'b1;
    repeat (4) begin
      @(negedge c1);
      if (done) done_seen = 1;
    end
    check("midreset no done", done_seen, 0);
    check("midreset still idle", cmd_ready, 1);
    mx = 0; my = 0; mh = 0;

    // Random targets, some with an obstacle appearing mid-route.
    for (int i = 0; i < 12; i++) begin
      rx = $urandom_range(0, (1 << W) - 1);
      ry = $urandom_range(0, (1 << W) - 1);
      rk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
      run_cmd("random", rx, ry, rk);
    end

    run_cmd("zero distance", mx, my, -1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
